program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader_pkg.sv | 34 +++
 rtl/program_loader_word_assembler.sv | 34 +++
 rtl/program_loader.sv | 116 +++++++++++
 tb/tb_program_loader.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: controller states, stream framing
// constants and the state-to-output decode used by the controller.
package program_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR0,
    ST_HDR1,
    ST_LOAD,
    ST_RUN,
    ST_DONE
  } state_t;

  localparam int WORD_BYTES = 4;
  localparam int HDR_BYTES  = 2;

  typedef struct packed {
    logic byte_ready;
    logic core_rst;
    logic busy;
    logic done;
  } flags_t;

  // Output flags that hold while the controller sits in state s.
  function automatic flags_t state_flags(input state_t s);
    flags_t f;
    f.byte_ready = (s == ST_HDR0) || (s == ST_HDR1) || (s == ST_LOAD);
    f.core_rst   = (s != ST_IDLE);
    f.busy       = (s != ST_IDLE) && (s != ST_DONE);
    f.done       = (s == ST_DONE);
    return f;
  endfunction

endpackage

// File: rtl/program_loader_word_assembler.sv
// Collects stream bytes little-endian into instruction words and flags the
// transfer that completes each word.
module word_assembler
  import program_loader_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      byte_en,
  input  logic [7:0]                byte_in,
  output logic [WORD_BYTES*8-1:0]   word,
  output logic                      word_complete
);

  localparam int WORD_W = WORD_BYTES * 8;

  logic [1:0]        byte_idx;
  logic [WORD_W-1:0] shift_reg;

  // New bytes enter at the top so the first byte ends up in [7:0].
  assign word          = {byte_in, shift_reg[WORD_W-1:8]};
  assign word_complete = byte_en && (byte_idx == 2'(WORD_BYTES - 1));

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      byte_idx  <= '0;
      shift_reg <= '0;
    end else if (byte_en) begin
      byte_idx  <= byte_idx + 2'd1;
      shift_reg <= word;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Streams a length-prefixed program into a core's instruction memory, then
// releases the core for a fixed number of cycles and records its last result.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int INSTRUCTION_LEN = 32,
  parameter int DATA_LEN        = 64,
  parameter int COUNT_LEN       = 10,
  parameter int RUN_CYCLES      = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [7:0]                 byte_in,
  input  logic                       byte_valid,
  output logic                       byte_ready,
  output logic                       core_rst,
  output logic                       ins_write,
  output logic [INSTRUCTION_LEN-1:0] instruction_in,
  input  logic [DATA_LEN-1:0]        res,
  output logic [DATA_LEN-1:0]        last_res,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  localparam int RUN_W = $clog2(RUN_CYCLES + 1);

  state_t                  state;
  state_t                  state_nxt;
  logic [COUNT_LEN-1:0]    count;
  logic [COUNT_LEN-1:0]    hdr_count;
  logic [RUN_W-1:0]        run_cnt;
  logic                    transfer;
  logic                    start_ok;
  logic                    run_expire;
  logic                    asm_en;
  logic                    word_complete;
  logic [WORD_BYTES*8-1:0] word;

  assign transfer   = byte_valid && byte_ready;
  assign start_ok   = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign asm_en     = transfer && (state == ST_LOAD);
  // Header high byte is truncated so bits beyond COUNT_LEN are ignored.
  assign hdr_count  = COUNT_LEN'({byte_in, count[7:0]});
  assign run_expire = !ins_write && (run_cnt == RUN_W'(RUN_CYCLES - 1));

  word_assembler u_word_assembler (
    .clk           (clk),
    .rst           (rst),
    .clear         (start_ok),
    .byte_en       (asm_en),
    .byte_in       (byte_in),
    .word          (word),
    .word_complete (word_complete)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: if (start)         state_nxt = ST_HDR0;
      ST_HDR0:          if (transfer)      state_nxt = ST_HDR1;
      ST_HDR1:          if (transfer)      state_nxt = (hdr_count == '0) ? ST_DONE : ST_LOAD;
      ST_LOAD:          if (word_complete && count == COUNT_LEN'(1)) state_nxt = ST_RUN;
      ST_RUN:           if (run_expire)    state_nxt = ST_DONE;
      default:                             state_nxt = ST_IDLE;
    endcase
  end

  // Flags are registered from the next state so they change with the state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= ST_IDLE;
      {byte_ready, core_rst, busy, done} <= state_flags(ST_IDLE);
      ins_write      <= 1'b0;
      instruction_in <= '0;
      last_res       <= '0;
      err            <= 1'b0;
      count          <= '0;
      run_cnt        <= '0;
    end else begin
      state     <= state_nxt;
      {byte_ready, core_rst, busy, done} <= state_flags(state_nxt);
      ins_write <= word_complete;

      if (start_ok) begin
        err      <= 1'b0;
        last_res <= '0;
        count    <= '0;
        run_cnt  <= '0;
      end

      if (transfer && state == ST_HDR0)
        count <= COUNT_LEN'(byte_in);

      if (transfer && state == ST_HDR1) begin
        count <= hdr_count;
        if (hdr_count == '0)
          err <= 1'b1;
      end

      if (word_complete) begin
        instruction_in <= INSTRUCTION_LEN'(word);
        count          <= count - COUNT_LEN'(1);
      end

      // The cycle carrying the final write pulse is not part of the run window.
      if (state == ST_RUN && !ins_write) begin
        run_cnt <= run_cnt + RUN_W'(1);
        if (res != '0)
          last_res <= res;
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed scenarios plus randomized
// programs checked against a stream-level model of the expected core writes.
module tb_program_loader;

  localparam int INSTRUCTION_LEN = 32;
  localparam int DATA_LEN        = 64;
  localparam int COUNT_LEN       = 10;
  localparam int RUN_CYCLES      = 8;

  logic                       clk = 1'b0;
  logic                       rst = 1'b0;
  logic                       start = 1'b0;
  logic [7:0]                 byte_in = '0;
  logic                       byte_valid = 1'b0;
  logic                       byte_ready;
  logic                       core_rst;
  logic                       ins_write;
  logic [INSTRUCTION_LEN-1:0] instruction_in;
  logic [DATA_LEN-1:0]        res = '0;
  logic [DATA_LEN-1:0]        last_res;
  logic                       busy;
  logic                       done;
  logic                       err;

  program_loader #(
    .INSTRUCTION_LEN (INSTRUCTION_LEN),
    .DATA_LEN        (DATA_LEN),
    .COUNT_LEN       (COUNT_LEN),
    .RUN_CYCLES      (RUN_CYCLES)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .byte_in        (byte_in),
    .byte_valid     (byte_valid),
    .byte_ready     (byte_ready),
    .core_rst       (core_rst),
    .ins_write      (ins_write),
    .instruction_in (instruction_in),
    .res            (res),
    .last_res       (last_res),
    .busy           (busy),
    .done           (done),
    .err            (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [31:0] word;
  } pulse_t;

  pulse_t pulses[$];
  pulse_t mon_p;

  always @(negedge clk) begin
    if (ins_write === 1'b1) begin
      mon_p.cyc  = cyc;
      mon_p.word = instruction_in;
      pulses.push_back(mon_p);
    end
  end

  int checks = 0;
  int errors = 0;

  logic [7:0]  stream[$];
  int          gaps[$];
  logic [63:0] res_seq[$];
  int          tcyc[$];
  int          start_poke_idx = -1;
  bit          run_poke = 1'b0;

  task automatic send_byte(input logic [7:0] b, input bit poke, output int tc);
    int waitn;
    @(negedge clk);
    byte_in    = b;
    byte_valid = 1'b1;
    start      = poke;
    waitn      = 0;
    while (byte_ready !== 1'b1 && waitn < 50) begin
      @(negedge clk);
      waitn++;
    end
    if (byte_ready !== 1'b1) begin
      checks++; errors++;
      $display("[TB] FAIL byte_ready_timeout got %b want 1", byte_ready);
    end
    tc = cyc + 1;
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
    start      = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Loads the global stream, drives res_seq through the run window and checks
  // every core write, the done timing and the captured result.
  task automatic run_program(input string name);
    int          cnt, k, first_done, tc;
    logic [63:0] exp_last, v;
    logic [31:0] w;
    pulses.delete();
    tcyc.delete();
    do_start();
    for (int i = 0; i < stream.size(); i++) begin
      idle(gaps[i]);
      send_byte(stream[i], (i == start_poke_idx), tc);
      tcyc.push_back(tc);
    end
    cnt        = int'({stream[1], stream[0]}) % (1 << COUNT_LEN);
    k          = tcyc[tcyc.size() - 1];
    exp_last   = '0;
    first_done = -1;
    for (int n = 0; n < RUN_CYCLES + 4; n++) begin
      @(negedge clk);
      if (done === 1'b1 && first_done < 0) first_done = cyc;
      v     = (n < res_seq.size()) ? res_seq[n] : 64'd0;
      res   = v;
      start = run_poke && (n == 2);
      if (n >= 1 && n <= RUN_CYCLES && v != 0) exp_last = v;
    end
    @(negedge clk);
    res   = '0;
    start = 1'b0;

    checks++;
    if (pulses.size() !== cnt) begin
      errors++;
      $display("[TB] FAIL %s pulse_count got %0d want %0d", name, pulses.size(), cnt);
    end
    for (int i = 0; i < cnt && i < pulses.size(); i++) begin
      w = {stream[2+4*i+3], stream[2+4*i+2], stream[2+4*i+1], stream[2+4*i]};
      checks++;
      if (pulses[i].word !== w) begin
        errors++;
        $display("[TB] FAIL %s word%0d got %h want %h", name, i, pulses[i].word, w);
      end
      checks++;
      if (pulses[i].cyc !== tcyc[2+4*i+3]) begin
        errors++;
        $display("[TB] FAIL %s pulse%0d_cycle got %0d want %0d", name, i, pulses[i].cyc, tcyc[2+4*i+3]);
      end
    end
    checks++;
    if (first_done !== k + 1 + RUN_CYCLES) begin
      errors++;
      $display("[TB] FAIL %s done_cycle got %0d want %0d", name, first_done, k + 1 + RUN_CYCLES);
    end
    checks++;
    if (last_res !== exp_last) begin
      errors++;
      $display("[TB] FAIL %s last_res got %h want %h", name, last_res, exp_last);
    end
    checks++;
    if ({done, busy, core_rst, err, byte_ready} !== 5'b10100) begin
      errors++;
      $display("[TB] FAIL %s done_flags got %b want 10100", name, {done, busy, core_rst, err, byte_ready});
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({byte_ready, ins_write, core_rst, busy, done, err} !== 6'b0 ||
        instruction_in !== '0 || last_res !== '0) begin
      errors++;
      $display("[TB] FAIL reset_values got flags %b ins %h last %h want 0",
               {byte_ready, ins_write, core_rst, busy, done, err}, instruction_in, last_res);
    end
    rst = 1'b1;
    do_start();
    checks++;
    if ({byte_ready, busy, core_rst, done} !== 4'b1110) begin
      errors++;
      $display("[TB] FAIL start_to_hdr0 got %b want 1110", {byte_ready, busy, core_rst, done});
    end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_two_words();
    stream  = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h00, 8'h00, 8'h00};
    gaps    = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    res_seq = '{};
    run_program("two_words");
    checks++;
    if (pulses.size() == 2 && pulses[1].cyc - pulses[0].cyc !== 4) begin
      errors++;
      $display("[TB] FAIL two_words_spacing got %0d want 4", pulses[1].cyc - pulses[0].cyc);
    end else if (pulses.size() != 2) begin
      errors++;
      $display("[TB] FAIL two_words_spacing got %0d pulses want 2", pulses.size());
    end
  endtask

  task automatic test_gap();
    stream  = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    gaps    = '{0, 0, 0, 0, 3, 0};
    res_seq = '{};
    run_program("gap");
    checks++;
    if (pulses.size() < 1 || pulses[0].cyc - tcyc[2] !== 3 + 3) begin
      errors++;
      $display("[TB] FAIL gap_delay got %0d want 6", (pulses.size() > 0) ? pulses[0].cyc - tcyc[2] : -1);
    end
  endtask

  task automatic test_run_res();
    stream  = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    gaps    = '{0, 0, 0, 0, 0, 0};
    res_seq = '{64'd0, 64'd0, 64'd5, 64'd0, 64'd9, 64'd0};
    run_program("run_res");
    checks++;
    if (last_res !== 64'd9) begin
      errors++;
      $display("[TB] FAIL run_res_value got %0d want 9", last_res);
    end
  endtask

  task automatic test_start_ignored();
    stream         = '{8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    gaps           = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    res_seq        = '{64'h77, 64'h0, 64'h0, 64'hDEAD, 64'h0};
    start_poke_idx = 4;
    run_poke       = 1'b1;
    run_program("start_ignored");
    start_poke_idx = -1;
    run_poke       = 1'b0;
  endtask

  task automatic test_done_restart_zero_len();
    int tc;
    do_start();
    checks++;
    if ({busy, byte_ready, done, core_rst} !== 4'b1101 || last_res !== '0) begin
      errors++;
      $display("[TB] FAIL restart_from_done got %b last %h want 1101 last 0",
               {busy, byte_ready, done, core_rst}, last_res);
    end
    pulses.delete();
    send_byte(8'h00, 1'b0, tc);
    send_byte(8'h00, 1'b0, tc);
    checks++;
    if ({done, err, core_rst, busy, byte_ready} !== 5'b11100) begin
      errors++;
      $display("[TB] FAIL zero_len_flags got %b want 11100", {done, err, core_rst, busy, byte_ready});
    end
    idle(3);
    checks++;
    if (err !== 1'b1 || pulses.size() !== 0) begin
      errors++;
      $display("[TB] FAIL zero_len_sticky got err %b pulses %0d want 1 0", err, pulses.size());
    end
    do_start();
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL err_clear_on_start got %b want 0", err);
    end
  endtask

  task automatic test_reset_mid();
    int tc;
    send_byte(8'h01, 1'b0, tc);
    send_byte(8'h00, 1'b0, tc);
    send_byte(8'h55, 1'b0, tc);
    send_byte(8'h66, 1'b0, tc);
    send_byte(8'h77, 1'b0, tc);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({byte_ready, ins_write, core_rst, busy, done, err} !== 6'b0 ||
        instruction_in !== '0 || last_res !== '0) begin
      errors++;
      $display("[TB] FAIL reset_mid got flags %b ins %h last %h want 0",
               {byte_ready, ins_write, core_rst, busy, done, err}, instruction_in, last_res);
    end
    rst     = 1'b1;
    stream  = '{8'h01, 8'h00, 8'hA1, 8'hB2, 8'hC3, 8'hD4};
    gaps    = '{0, 0, 0, 0, 0, 0};
    res_seq = '{64'h0, 64'h3};
    run_program("reset_mid_reload");
  endtask

  task automatic test_random();
    int cnt;
    for (int it = 0; it < 6; it++) begin
      cnt = $urandom_range(1, 3);
      stream.delete(); gaps.delete(); res_seq.delete();
      stream.push_back(8'(cnt));
      stream.push_back(8'($urandom_range(0, 63) << 2));
      for (int i = 0; i < 4 * cnt; i++) stream.push_back(8'($urandom));
      for (int i = 0; i < stream.size(); i++) gaps.push_back($urandom_range(0, 2));
      for (int i = 0; i < RUN_CYCLES + 4; i++)
        res_seq.push_back(($urandom_range(0, 1) == 1) ? {32'($urandom), 32'($urandom)} : 64'd0);
      run_program($sformatf("random%0d", it));
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_two_words();
    test_gap();
    test_run_res();
    test_start_ignored();
    test_done_restart_zero_len();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
